pwm_dac_bank: RTL

PWM_DAC_BANK -- requirements
Module: pwm_dac_bank

---
 rtl/pwm_dac_bank.sv | 93 +++++++++
 1 files changed

// File: rtl/pwm_dac_bank.sv
// Bank of CH PWM DAC channels sharing one free-running counter, with period-coherent duty updates.
// Optional build macro PWM_DAC_BANK_TWOS_COMP_EN: accept two's-complement duty and store it as offset binary.
module pwm_dac_bank #(
    parameter int unsigned CH  = 4,
    parameter int unsigned PW  = 12,
    parameter int unsigned DIV = 8192,
    localparam int unsigned CW = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [CW-1:0] wr_ch,
    input  logic [PW-1:0] wr_data,
    output logic          wr_err,
    output logic [CH-1:0] pwm_out,
    output logic          period_start,
    output logic          sample_tick
);

    localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] CNT_MAX  = '1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    logic [PW-1:0] cnt;
    logic [DW-1:0] div_cnt;
    logic [PW-1:0] shadow [CH];
    logic [PW-1:0] active [CH];
    logic [PW-1:0] wr_conv_c;
    logic          wr_bad_c;
    logic          wrap_c;

    // Input duty format conversion
    always_comb begin
`ifdef PWM_DAC_BANK_TWOS_COMP_EN
        wr_conv_c = {~wr_data[PW-1], wr_data[PW-2:0]};
`else
        wr_conv_c = wr_data;
`endif
    end

    assign wr_bad_c = wr_en && (32'(wr_ch) >= CH);
    assign wrap_c   = (cnt == CNT_MAX);

    // Shared PWM counter; period_start marks the cycle the cnt=0 outputs appear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            period_start <= 1'b0;
        end else begin
            cnt          <= cnt + PW'(1);
            period_start <= (cnt == '0);
        end
    end

    // Sample-rate divider, independent of the PWM counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt     <= '0;
            sample_tick <= 1'b0;
        end else begin
            sample_tick <= (div_cnt == DIV_LAST);
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
        end
    end

    // Duty registers: shadows take writes, actives reload from the old shadows at the wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_err  <= 1'b0;
            pwm_out <= '0;
            for (int i = 0; i < CH; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            wr_err <= wr_bad_c;
            for (int i = 0; i < CH; i++) begin
                pwm_out[i] <= (cnt < active[i]);
                if (wrap_c) begin
                    active[i] <= shadow[i];
                end
                if (wr_en && (wr_ch == CW'(i))) begin
                    shadow[i] <= wr_conv_c;
                end
            end
        end
    end

endmodule
